// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, canonical constants,
// divider issue FSM encoding and the result flag bundle.
package fpu_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } div_state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic div_by_zero;
        logic exception;
    } fp_flags_t;

    function automatic logic [31:0] fp_signed_inf(input logic s);
        return {s, FP_POS_INF[30:0]};
    endfunction

    function automatic logic [31:0] fp_signed_zero(input logic s);
        return {s, 31'b0};
    endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational IEEE-754 single classifier; denormals report as zero so the
// divider path only ever sees normal operands.
module fp_class
    import fpu_pkg::*;
(
    input  logic [31:0]         value,
    output logic                is_zero,
    output logic                is_inf,
    output logic                is_nan,
    output logic                sign,
    output logic [FP_EXP_W-1:0] exp,
    output logic [FP_MAN_W-1:0] man
);

    assign sign    = value[31];
    assign exp     = value[30:23];
    assign man     = value[22:0];

    assign is_zero = (exp == '0);
    assign is_inf  = (&exp) && (man == '0);
    assign is_nan  = (&exp) && (man != '0);

endmodule

// File: rtl/fp_div_issue.sv
// Issue/completion controller for the serial divider: screens special cases
// and exponent range, launches the core for the rest and holds the result.
module fp_div_issue
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        div_start,
    output logic [31:0] div_op_a,
    output logic [31:0] div_op_b,
    input  logic        div_done,
    input  logic [31:0] div_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        exception
);

    div_state_t state, state_next;

    logic                a_zero, a_inf, a_nan, a_sign;
    logic                b_zero, b_inf, b_nan, b_sign;
    logic [FP_EXP_W-1:0] a_exp, b_exp;
    logic [FP_MAN_W-1:0] a_man, b_man;
    logic                a_norm, b_norm;
    logic                res_sign;
    logic                man_lt;
    logic signed [9:0]   exp_est;

    logic                bypass;
    logic [31:0]         bypass_res;
    fp_flags_t           bypass_flags;

    logic [31:0]         op_a_q, op_b_q;
    logic [31:0]         res_q;
    fp_flags_t           flags_q;
    logic                sign_q;
    logic                wait_first;
    logic                core_done;

    fp_class u_class_a (
        .value   (op_a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .sign    (a_sign),
        .exp     (a_exp),
        .man     (a_man)
    );

    fp_class u_class_b (
        .value   (op_b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .sign    (b_sign),
        .exp     (b_exp),
        .man     (b_man)
    );

    assign a_norm   = !a_zero && !a_inf && !a_nan;
    assign b_norm   = !b_zero && !b_inf && !b_nan;
    assign res_sign = a_sign ^ b_sign;

    // Leading ones cancel, so comparing raw mantissas equals comparing {1,man}.
    assign man_lt   = (a_man < b_man);
    assign exp_est  = {2'b00, a_exp} - {2'b00, b_exp} + 10'(FP_BIAS) - {9'b0, man_lt};

    always_comb begin
        bypass       = 1'b1;
        bypass_res   = '0;
        bypass_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            bypass_res             = FP_CANON_NAN;
            bypass_flags.exception = 1'b1;
        end else if (a_norm && b_zero) begin
            bypass_res               = fp_signed_inf(res_sign);
            bypass_flags.div_by_zero = 1'b1;
        end else if (a_inf) begin
            bypass_res = fp_signed_inf(res_sign);
        end else if (a_zero || b_inf) begin
            bypass_res = fp_signed_zero(res_sign);
        end else if (exp_est >= 10'sd255) begin
            bypass_res            = fp_signed_inf(res_sign);
            bypass_flags.overflow = 1'b1;
        end else if (exp_est <= 10'sd0) begin
            bypass_res             = fp_signed_zero(res_sign);
            bypass_flags.underflow = 1'b1;
        end else begin
            bypass = 1'b0;
        end
    end

    // The core may still show a stale done level in the cycle right after start.
    assign core_done = div_done && !wait_first;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = bypass ? OUT : START;
            START:   state_next = WAIT;
            WAIT:    if (core_done) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            sign_q     <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a_q  <= op_a;
                        op_b_q  <= op_b;
                        sign_q  <= res_sign;
                        res_q   <= bypass_res;
                        flags_q <= bypass_flags;
                    end
                end
                START: wait_first <= 1'b1;
                WAIT: begin
                    wait_first <= 1'b0;
                    // Overwrites the core's sign bit with the operand sign.
                    if (core_done) begin
                        res_q   <= div_res ^ {div_res[31] ^ sign_q, 31'b0};
                        flags_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign div_start   = (state == START);
    assign out_valid   = (state == OUT);
    assign div_op_a    = op_a_q;
    assign div_op_b    = op_b_q;
    assign res         = res_q;
    assign overflow    = flags_q.overflow;
    assign underflow   = flags_q.underflow;
    assign div_by_zero = flags_q.div_by_zero;
    assign exception   = flags_q.exception;

endmodule
